// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared constants and FSM state encoding for the BCD-to-binary converter.
// Contents: default digit count, result width, accumulator width, state enum.
package bcd_to_bin_seq_pkg;

  localparam int unsigned N_DIGITS = 10;
  localparam int unsigned BIN_W    = 32;
  // Four guard bits keep acc*10+d from wrapping for ten digits (max < 2^34).
  localparam int unsigned ACC_W    = BIN_W + 4;
  localparam int unsigned DIGIT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/result bundle between a requester and the BCD-to-binary converter.
// Signals: start (request pulse), bcd (packed digits, MSD in top nibble),
//          busy, done (one-cycle pulse), bin, overflow, invalid.
// Modports: master = requester side, slave = converter side.
interface bcd_to_bin_seq_if #(
  parameter int unsigned N_DIGITS = bcd_to_bin_seq_pkg::N_DIGITS,
  parameter int unsigned BIN_W    = bcd_to_bin_seq_pkg::BIN_W
);

  logic                    start;
  logic [4*N_DIGITS-1:0]   bcd;
  logic                    busy;
  logic                    done;
  logic [BIN_W-1:0]        bin;
  logic                    overflow;
  logic                    invalid;

  modport master (
    output start, bcd,
    input  busy, done, bin, overflow, invalid
  );

  modport slave (
    input  start, bcd,
    output busy, done, bin, overflow, invalid
  );

endinterface

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add: mac_c = acc*10 + digit,
// built from (acc<<3) + (acc<<1) so no multiplier is inferred.
// Ports: acc (accumulator in), digit (BCD digit), mac_c (result).
module bcd_mac10 #(
  parameter int unsigned ACC_W = bcd_to_bin_seq_pkg::ACC_W
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] mac_c
);

  assign mac_c = (acc << 3) + (acc << 1) + ACC_W'(digit);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one decimal digit per clock.
// Ports: clk, rst_n (synchronous, active-low), bus (slave side of
//        bcd_to_bin_seq_if: start/bcd in; busy/done/bin/overflow/invalid out).
// Invalid digits short-circuit straight to DONE; results saturate on overflow.
module bcd_to_bin_seq #(
  parameter int unsigned N_DIGITS = bcd_to_bin_seq_pkg::N_DIGITS,
  parameter int unsigned BIN_W    = bcd_to_bin_seq_pkg::BIN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_to_bin_seq_if.slave  bus
);

  localparam int unsigned ACC_W = BIN_W + 4;
  localparam int unsigned BCD_W = 4 * N_DIGITS;
  localparam int unsigned CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  import bcd_to_bin_seq_pkg::*;

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   sr_q, sr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               ovf_q, ovf_d;
  logic               inv_q, inv_d;

  logic [ACC_W-1:0]   mac_c;
  logic [N_DIGITS-1:0] nib_bad_c;
  logic               any_bad_c;

  // Per-digit range check on the live input, used only in the start cycle.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_nib
    assign nib_bad_c[g] = (bus.bcd[4*g +: 4] > 4'd9);
  end
  assign any_bad_c = |nib_bad_c;

  bcd_mac10 #(.ACC_W(ACC_W)) u_mac (
    .acc   (acc_q),
    .digit (sr_q[BCD_W-1 -: 4]),
    .mac_c (mac_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
      ovf_q   <= ovf_d;
      inv_q   <= inv_d;
    end
  end

  // Next-state and next-register logic; result registers load on DONE entry.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    inv_d   = inv_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d  = bus.bcd;
          acc_d = '0;
          cnt_d = CNT_W'(N_DIGITS - 1);
          bin_d = '0;
          ovf_d = 1'b0;
          inv_d = 1'b0;
          if (any_bad_c) begin
            inv_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CONV;
          end
        end
      end

      CONV: begin
        acc_d = mac_c;
        sr_d  = sr_q << 4;
        if (cnt_q == '0) begin
          // Last digit: mac_c is the final value, so results load now.
          state_d = DONE;
          done_d  = 1'b1;
          if (|mac_c[ACC_W-1:BIN_W]) begin
            ovf_d = 1'b1;
            bin_d = '1;
          end else begin
            bin_d = mac_c[BIN_W-1:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bin      = bin_q;
  assign bus.overflow = ovf_q;
  assign bus.invalid  = inv_q;

endmodule
